// File: rtl/cla_adder_16.sv
`default_nettype none
// ============================================================================
// Module   : cla_adder_16
// Purpose  : Registered 16-bit two-level carry-lookahead adder with group P/G.
// Revision : 1.0
// ============================================================================
module cla_adder_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Cin,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] S,
    output logic        Cout,
    output logic        P,
    output logic        G
);

    localparam int c_SLICES  = 4;
    localparam int c_SLICE_W = 4;

    logic [15:0]         w_p;
    logic [15:0]         w_g;
    logic [15:0]         w_bc;
    logic [c_SLICES-1:0] w_sp;
    logic [c_SLICES-1:0] w_sg;
    logic [c_SLICES-1:0] w_sc;
    logic                w_c16;
    logic                w_grp_p;
    logic                w_grp_g;
    logic [15:0]         w_sum;

    logic [15:0]         r_s;
    logic                r_cout;
    logic                r_p;
    logic                r_g;

    assign w_p = A ^ B;
    assign w_g = A & B;

    // Each slice expands its three internal carries directly from the slice
    // carry-in, so no bit waits on its neighbour.
    generate
        for (genvar k = 0; k < c_SLICES; k++) begin : g_slice
            localparam int c_B = k * c_SLICE_W;

            assign w_sp[k] = &w_p[c_B +: c_SLICE_W];
            assign w_sg[k] = w_g[c_B+3]
                           | (w_p[c_B+3] & w_g[c_B+2])
                           | (w_p[c_B+3] & w_p[c_B+2] & w_g[c_B+1])
                           | (w_p[c_B+3] & w_p[c_B+2] & w_p[c_B+1] & w_g[c_B]);

            assign w_bc[c_B]   = w_sc[k];
            assign w_bc[c_B+1] = w_g[c_B]
                               | (w_p[c_B] & w_sc[k]);
            assign w_bc[c_B+2] = w_g[c_B+1]
                               | (w_p[c_B+1] & w_g[c_B])
                               | (w_p[c_B+1] & w_p[c_B] & w_sc[k]);
            assign w_bc[c_B+3] = w_g[c_B+2]
                               | (w_p[c_B+2] & w_g[c_B+1])
                               | (w_p[c_B+2] & w_p[c_B+1] & w_g[c_B])
                               | (w_p[c_B+2] & w_p[c_B+1] & w_p[c_B] & w_sc[k]);
        end
    endgenerate

    // Second-level lookahead: slice carry-ins from slice P/G and Cin.
    assign w_sc[0] = Cin;
    assign w_sc[1] = w_sg[0]
                   | (w_sp[0] & Cin);
    assign w_sc[2] = w_sg[1]
                   | (w_sp[1] & w_sg[0])
                   | (w_sp[1] & w_sp[0] & Cin);
    assign w_sc[3] = w_sg[2]
                   | (w_sp[2] & w_sg[1])
                   | (w_sp[2] & w_sp[1] & w_sg[0])
                   | (w_sp[2] & w_sp[1] & w_sp[0] & Cin);

    assign w_grp_p = &w_sp;
    assign w_grp_g = w_sg[3]
                   | (w_sp[3] & w_sg[2])
                   | (w_sp[3] & w_sp[2] & w_sg[1])
                   | (w_sp[3] & w_sp[2] & w_sp[1] & w_sg[0]);
    assign w_c16   = w_grp_g | (w_grp_p & Cin);

    assign w_sum = w_p ^ w_bc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s    <= 16'h0000;
            r_cout <= 1'b0;
            r_p    <= 1'b0;
            r_g    <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_c16;
            r_p    <= w_grp_p;
            r_g    <= w_grp_g;
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;
    assign P    = r_p;
    assign G    = r_g;

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_adder_16
// Purpose  : Directed and random self-checking bench for cla_adder_16.
// Revision : 1.0
// ============================================================================
module tb_cla_adder_16;

    logic        clk;
    logic        rst_n;
    logic        Cin;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] S;
    logic        Cout;
    logic        P;
    logic        G;

    int n_vec;
    int n_err;

    cla_adder_16 u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .Cin  (Cin),
        .A    (A),
        .B    (B),
        .S    (S),
        .Cout (Cout),
        .P    (P),
        .G    (G)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present operands, wait one edge, then compare the registered result.
    task automatic run(input string tag, input logic rn, input logic [15:0] a,
                       input logic [15:0] b, input logic ci,
                       input logic [15:0] es, input logic ec,
                       input logic ep, input logic eg);
        rst_n = rn;
        A     = a;
        B     = b;
        Cin   = ci;
        @(posedge clk);
        #1;
        check({tag, ".S"},    {16'h0, S},     {16'h0, es});
        check({tag, ".Cout"}, {31'h0, Cout},  {31'h0, ec});
        check({tag, ".P"},    {31'h0, P},     {31'h0, ep});
        check({tag, ".G"},    {31'h0, G},     {31'h0, eg});
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] full;
        logic [16:0] nocarry;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        A     = 16'h0;
        B     = 16'h0;
        Cin   = 1'b0;
        @(posedge clk);
        #1;

        run("rst0", 1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        run("rst1", 1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);

        run("add7_1",   1'b1, 16'h0007, 16'h0001, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
        run("addC_3",   1'b1, 16'h000C, 16'h0003, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);
        run("addC_A",   1'b1, 16'h000C, 16'h000A, 1'b0, 16'h0016, 1'b0, 1'b0, 1'b0);
        run("add1C_13", 1'b1, 16'h001C, 16'h0013, 1'b0, 16'h002F, 1'b0, 1'b0, 1'b0);

        run("wrap1111", 1'b1, 16'hFFFF, 16'h1111, 1'b0, 16'h1110, 1'b1, 1'b0, 1'b1);
        run("wrapFFFF", 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1);

        run("prop_ci1", 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        run("prop_ci0", 1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);

        run("zero",     1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        run("hold",     1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a stream; the reset-cycle operands are dropped.
        run("pre_rst",  1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);
        run("mid_rst",  1'b0, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        run("post_rst", 1'b1, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ra      = 16'($urandom);
            rb      = 16'($urandom);
            rc      = 1'($urandom);
            full    = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
            nocarry = {1'b0, ra} + {1'b0, rb};
            run($sformatf("rnd%0d", i), 1'b1, ra, rb, rc,
                full[15:0], full[16], &(ra ^ rb), nocarry[16]);
            check($sformatf("rnd%0d.cons", i), {31'h0, Cout}, {31'h0, G | (P & rc)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
